// File: rtl/led_rgb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_rgb_pkg                                                          |
// | Shared types and defaults for the RGB LED blinker.                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package led_rgb_pkg;

  // Default width of the blink half-period and of the per-channel counter
  localparam int unsigned CNT_W_DEFAULT = 32;

  // Per-channel operating state
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    HOLD  = 2'd3
  } led_state_e;

endpackage
`default_nettype wire

// File: rtl/led_rgb_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_rgb_channel                                                      |
// | One LED channel: OFF/ON/BLINK/HOLD state machine, blink counter and  |
// | logical level register.                                              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module led_rgb_channel
  import led_rgb_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             soft_rst_ni,
  input  logic             enable_i,
  input  logic             mode_i,
  input  logic             holded_i,
  input  logic [CNT_W-1:0] duration_i,
  output logic             lvl_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  led_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] last_cnt;

  // Terminal count of a half-period; duration 0 behaves like duration 1
  always_comb begin
    last_cnt = '0;
    if (duration_i != '0) begin
      last_cnt = duration_i - CNT_ONE;
    end
  end

  // Next-state, counter and level selection; input priority is fixed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    if (!soft_rst_ni) begin
      state_d = OFF;
      cnt_d   = '0;
      lvl_d   = 1'b0;
    end else if (!enable_i && !holded_i) begin
      state_d = OFF;
      cnt_d   = '0;
      lvl_d   = 1'b0;
    end else if (!enable_i) begin
      // Freeze both level and blink phase
      state_d = HOLD;
    end else if (!mode_i) begin
      state_d = ON;
      cnt_d   = '0;
      lvl_d   = 1'b1;
    end else begin
      state_d = BLINK;
      if (state_q != BLINK) begin
        // Any entry into BLINK, including from HOLD, starts a fresh lit phase
        cnt_d = '0;
        lvl_d = 1'b1;
      end else if (cnt_q >= last_cnt) begin
        // >= so a shortened duration toggles at once instead of wrapping
        cnt_d = '0;
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State, counter and level registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OFF;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

  assign lvl_o = lvl_q;

endmodule
`default_nettype wire

// File: rtl/led_rgb_blinker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_rgb_blinker                                                      |
// | Three independent LED channels (R, G, B) with constant-on, blink,    |
// | hold and off behaviour, plus reset release synchronisation.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module led_rgb_blinker
  import led_rgb_pkg::*;
#(
  parameter bit          LED_ACTIVE_LOW = 1'b0,
  parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             user_resetn,
  input  logic             mode_r,
  input  logic             mode_g,
  input  logic             mode_b,
  input  logic             enable_r,
  input  logic             enable_g,
  input  logic             enable_b,
  input  logic             holded_r,
  input  logic             holded_g,
  input  logic             holded_b,
  input  logic [CNT_W-1:0] duration_r,
  input  logic [CNT_W-1:0] duration_g,
  input  logic [CNT_W-1:0] duration_b,
  output logic             LED_R,
  output logic             LED_G,
  output logic             LED_B,
  output logic             LED_R_STS,
  output logic             LED_G_STS,
  output logic             LED_B_STS
);

  logic [1:0] rst_sync_q;
  logic       rst_n;
  logic       lvl_r, lvl_g, lvl_b;

  // Reset asserts immediately, releases two aclk edges after aresetn rises
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  led_rgb_channel #(.CNT_W(CNT_W)) u_ch_r (
    .clk_i       (aclk),
    .rst_ni      (rst_n),
    .soft_rst_ni (user_resetn),
    .enable_i    (enable_r),
    .mode_i      (mode_r),
    .holded_i    (holded_r),
    .duration_i  (duration_r),
    .lvl_o       (lvl_r)
  );

  led_rgb_channel #(.CNT_W(CNT_W)) u_ch_g (
    .clk_i       (aclk),
    .rst_ni      (rst_n),
    .soft_rst_ni (user_resetn),
    .enable_i    (enable_g),
    .mode_i      (mode_g),
    .holded_i    (holded_g),
    .duration_i  (duration_g),
    .lvl_o       (lvl_g)
  );

  led_rgb_channel #(.CNT_W(CNT_W)) u_ch_b (
    .clk_i       (aclk),
    .rst_ni      (rst_n),
    .soft_rst_ni (user_resetn),
    .enable_i    (enable_b),
    .mode_i      (mode_b),
    .holded_i    (holded_b),
    .duration_i  (duration_b),
    .lvl_o       (lvl_b)
  );

  // Pins follow the level registers through a constant XOR only
  assign LED_R_STS = lvl_r;
  assign LED_G_STS = lvl_g;
  assign LED_B_STS = lvl_b;
  assign LED_R     = lvl_r ^ LED_ACTIVE_LOW;
  assign LED_G     = lvl_g ^ LED_ACTIVE_LOW;
  assign LED_B     = lvl_b ^ LED_ACTIVE_LOW;

endmodule
`default_nettype wire

// File: tb/tb_led_rgb_blinker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_rgb_blinker                                                   |
// | Directed self-checking bench for led_rgb_blinker.                    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_led_rgb_blinker;

  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          aresetn, user_resetn;
  logic          mode_r, mode_g, mode_b;
  logic          enable_r, enable_g, enable_b;
  logic          holded_r, holded_g, holded_b;
  logic [CW-1:0] duration_r, duration_g, duration_b;
  logic          LED_R, LED_G, LED_B, LED_R_STS, LED_G_STS, LED_B_STS;

  // Second instance, active-low pins, red constantly on
  logic          aresetn_al;
  logic          en_r_al;
  logic          mode_r_al;
  logic          LED_R_al, LED_G_al, LED_B_al, STS_R_al, STS_G_al, STS_B_al;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 aclk = ~aclk;

  led_rgb_blinker dut (
    .aclk(aclk), .aresetn(aresetn), .user_resetn(user_resetn),
    .mode_r(mode_r), .mode_g(mode_g), .mode_b(mode_b),
    .enable_r(enable_r), .enable_g(enable_g), .enable_b(enable_b),
    .holded_r(holded_r), .holded_g(holded_g), .holded_b(holded_b),
    .duration_r(duration_r), .duration_g(duration_g), .duration_b(duration_b),
    .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B),
    .LED_R_STS(LED_R_STS), .LED_G_STS(LED_G_STS), .LED_B_STS(LED_B_STS)
  );

  led_rgb_blinker #(.LED_ACTIVE_LOW(1'b1)) dut_al (
    .aclk(aclk), .aresetn(aresetn_al), .user_resetn(1'b1),
    .mode_r(mode_r_al), .mode_g(1'b0), .mode_b(1'b0),
    .enable_r(en_r_al), .enable_g(1'b0), .enable_b(1'b0),
    .holded_r(1'b0), .holded_g(1'b0), .holded_b(1'b0),
    .duration_r(32'd0), .duration_g(32'd0), .duration_b(32'd0),
    .LED_R(LED_R_al), .LED_G(LED_G_al), .LED_B(LED_B_al),
    .LED_R_STS(STS_R_al), .LED_G_STS(STS_G_al), .LED_B_STS(STS_B_al)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    {mode_r, mode_g, mode_b}       = 3'b000;
    {enable_r, enable_g, enable_b} = 3'b000;
    {holded_r, holded_g, holded_b} = 3'b000;
    duration_r = '0;
    duration_g = '0;
    duration_b = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    user_resetn = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({LED_R, LED_G, LED_B, LED_R_STS, LED_G_STS, LED_B_STS} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000",
               {LED_R, LED_G, LED_B, LED_R_STS, LED_G_STS, LED_B_STS});
    else n_pass++;
    aresetn = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({LED_R_STS, LED_G_STS, LED_B_STS} !== 3'b000)
      $display("FAIL reset_release_idle: got %b want 000", {LED_R_STS, LED_G_STS, LED_B_STS});
    else n_pass++;
  endtask

  task automatic test_blink_r();
    logic exp;
    enable_r = 1'b1; mode_r = 1'b1; duration_r = 32'd4;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      exp = (((cyc - 1) % 8) < 4);
      n_checks++;
      if ({LED_R_STS, LED_G_STS, LED_B_STS, LED_R} !== {exp, 1'b0, 1'b0, exp})
        $display("FAIL blink_r_cyc%0d: got %b want %b", cyc,
                 {LED_R_STS, LED_G_STS, LED_B_STS, LED_R}, {exp, 1'b0, 1'b0, exp});
      else n_pass++;
    end
    clear_inputs();
    tick();
    n_checks++;
    if (LED_R_STS !== 1'b0) $display("FAIL blink_r_force_off: got %b want 0", LED_R_STS);
    else n_pass++;
  endtask

  task automatic test_min_duration();
    logic exp;
    enable_g = 1'b1; mode_g = 1'b1; duration_g = 32'd0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc == 7) duration_g = 32'd1;
      tick();
      exp = cyc[0];
      n_checks++;
      if (LED_G_STS !== exp)
        $display("FAIL min_dur_cyc%0d: got %b want %b", cyc, LED_G_STS, exp);
      else n_pass++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_duration_change();
    logic exp;
    enable_b = 1'b1; mode_b = 1'b1; duration_b = 32'd10;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      n_checks++;
      if (LED_B_STS !== 1'b1) $display("FAIL dur10_cyc%0d: got %b want 1", cyc, LED_B_STS);
      else n_pass++;
    end
    // Counter now sits at 7, past the new terminal count of 2
    duration_b = 32'd3;
    for (int cyc = 9; cyc <= 20; cyc++) begin
      tick();
      exp = (((cyc - 9) / 3) % 2) != 0;
      n_checks++;
      if (LED_B_STS !== exp)
        $display("FAIL dur_change_cyc%0d: got %b want %b", cyc, LED_B_STS, exp);
      else n_pass++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_hold();
    enable_r = 1'b1; mode_r = 1'b1; duration_r = 32'd4;
    repeat (5) tick();
    n_checks++;
    if (LED_R_STS !== 1'b0) $display("FAIL hold_pre_level: got %b want 0", LED_R_STS);
    else n_pass++;
    enable_r = 1'b0; holded_r = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      n_checks++;
      if (LED_R_STS !== 1'b0) $display("FAIL hold_cyc%0d: got %b want 0", cyc, LED_R_STS);
      else n_pass++;
    end
    enable_r = 1'b1;
    tick();
    n_checks++;
    if (LED_R_STS !== 1'b1) $display("FAIL hold_reenable: got %b want 1", LED_R_STS);
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_const_on();
    enable_r = 1'b1; mode_r = 1'b0; duration_r = 32'd2;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      n_checks++;
      if ({LED_R_STS, LED_R} !== 2'b11) $display("FAIL const_on_cyc%0d: got %b want 11", cyc, {LED_R_STS, LED_R});
      else n_pass++;
    end
    enable_r = 1'b0; holded_r = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (LED_R_STS !== 1'b1) $display("FAIL hold_lit: got %b want 1", LED_R_STS);
    else n_pass++;
    holded_r = 1'b0;
    tick();
    n_checks++;
    if (LED_R_STS !== 1'b0) $display("FAIL hold_to_off: got %b want 0", LED_R_STS);
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_user_reset();
    logic [2:0] exp_tab [0:3];
    exp_tab[0] = 3'b111; exp_tab[1] = 3'b111; exp_tab[2] = 3'b110; exp_tab[3] = 3'b010;
    enable_r = 1'b1; enable_g = 1'b1; enable_b = 1'b1;
    mode_r = 1'b1; mode_g = 1'b1; mode_b = 1'b1;
    duration_r = 32'd3; duration_g = 32'd5; duration_b = 32'd2;
    repeat (5) tick();
    n_checks++;
    if ({LED_R_STS, LED_G_STS, LED_B_STS} !== 3'b011)
      $display("FAIL ureset_pre: got %b want 011", {LED_R_STS, LED_G_STS, LED_B_STS});
    else n_pass++;
    user_resetn = 1'b0;
    tick();
    n_checks++;
    if ({LED_R_STS, LED_G_STS, LED_B_STS} !== 3'b000)
      $display("FAIL ureset_clear: got %b want 000", {LED_R_STS, LED_G_STS, LED_B_STS});
    else n_pass++;
    user_resetn = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      n_checks++;
      if ({LED_R_STS, LED_G_STS, LED_B_STS} !== exp_tab[cyc])
        $display("FAIL ureset_restart_cyc%0d: got %b want %b", cyc + 1,
                 {LED_R_STS, LED_G_STS, LED_B_STS}, exp_tab[cyc]);
      else n_pass++;
    end
    // Asynchronous reset mid-blink, then synchronised release
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({LED_R_STS, LED_G_STS, LED_B_STS} !== 3'b000)
      $display("FAIL areset_async_clear: got %b want 000", {LED_R_STS, LED_G_STS, LED_B_STS});
    else n_pass++;
    tick();
    aresetn = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick();
      n_checks++;
      if ({LED_R_STS, LED_G_STS, LED_B_STS} !== ((cyc == 3) ? 3'b111 : 3'b000))
        $display("FAIL areset_release_cyc%0d: got %b want %b", cyc,
                 {LED_R_STS, LED_G_STS, LED_B_STS}, (cyc == 3) ? 3'b111 : 3'b000);
      else n_pass++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_active_low();
    en_r_al = 1'b1; mode_r_al = 1'b0;
    aresetn_al = 1'b1;
    repeat (4) tick();
    n_checks++;
    if ({LED_R_al, STS_R_al, LED_G_al, STS_G_al, LED_B_al, STS_B_al} !== 6'b011010)
      $display("FAIL active_low_on: got %b want 011010",
               {LED_R_al, STS_R_al, LED_G_al, STS_G_al, LED_B_al, STS_B_al});
    else n_pass++;
    #2;
    aresetn_al = 1'b0;
    #1;
    n_checks++;
    if ({LED_R_al, STS_R_al} !== 2'b10)
      $display("FAIL active_low_async_reset: got %b want 10", {LED_R_al, STS_R_al});
    else n_pass++;
  endtask

  initial begin
    aresetn = 1'b1; aresetn_al = 1'b1; user_resetn = 1'b1;
    en_r_al = 1'b0; mode_r_al = 1'b0;
    clear_inputs();
    #1;
    aresetn = 1'b0; aresetn_al = 1'b0;
    test_reset();
    test_blink_r();
    test_min_duration();
    test_duration_change();
    test_hold();
    test_const_on();
    test_user_reset();
    test_active_low();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
